mdu_unit: RTL and testbench
===========================

# mdu_unit

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It executes mult/multu/div/divu, madd/maddu/msub/msubu and mthi/mtlo against private HI/LO registers, and exposes `busy` to the stall controller. Start is masked by the exception request `req`, so a flushed instruction never changes HI/LO. Width and multiply latency are parameters. Division is a real iterative restoring divider rather than a delayed combinational result.

## Interface
- `WIDTH`, 32, operand and HI/LO width (≥8, even).
- `MUL_CYCLES`, 5, busy cycles for all multiply-class ops (≥1).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req` input 1: exception/interrupt request from CP0; masks `start`.
- `start` input 1: launch op; sampled at the rising edge.
- `op` input 4: operation code, `MDU_*` constants.
- `d1` input WIDTH: rs operand; also the mthi/mtlo data.
- `d2` input WIDTH: rt operand.
- `busy` output 1: an operation is in flight.
- `hi` output WIDTH: HI register (mfhi source).
- `lo` output WIDTH: LO register (mflo source).

## Operation
- Ops: `MDU_NONE`, `MULT`, `MULTU`, `DIV`, `DIVU`, `MADD`, `MADDU`, `MSUB`, `MSUBU`, `MTHI`, `MTLO`.
- Accept condition: `start && !req && !busy && op!=NONE`. Otherwise the request is ignored and causes no state change. The stall unit guarantees no start while busy; the ignore rule is the defined fallback.
- MTHI/MTLO: write `d1` to HI/LO at the accepting edge. No busy cycles.
- Multiply class: at the accepting edge, latch the full 2·WIDTH product (signed or unsigned per op) and the prior {HI,LO}.
  - MADD* writes {HI,LO} + product; MSUB* writes {HI,LO} − product. Both are modulo 2^(2·WIDTH).
  - HI/LO are written at the edge ending the last busy cycle.
- Divide class: sub-module performs WIDTH restoring iterations on magnitudes, then 1 sign-fixup cycle.
  - Quotient truncates toward zero → LO; remainder takes the dividend's sign → HI.
  - −2^(WIDTH−1) / −1 → LO = −2^(WIDTH−1), HI = 0.
  - Divide by zero: full latency runs, HI/LO unchanged.
- HI/LO outputs are the register values. Results are never visible before the final write edge.
- `req` during busy does not abort. The in-flight instruction has already passed M, so it completes normally.
- FSM states:
  - IDLE → MUL on accepted multiply-class op.
  - IDLE → DIV on accepted divide-class op.
  - MUL → IDLE when count = MUL_CYCLES.
  - DIV → IDLE after WIDTH+1 cycles.
  - Any state → IDLE on reset.

## Timing
- Reset values (asynchronous, immediate): `hi`=0, `lo`=0, `busy`=0, FSM=IDLE, counters=0. Reset mid-operation discards the operation.
- Accept at edge T:
  - Multiply class: `busy`=1 for cycles T+1..T+MUL_CYCLES; HI/LO are updated at the edge ending cycle T+MUL_CYCLES; `busy`=0 from the next cycle.
  - Divide class: `busy`=1 for WIDTH+1 cycles; HI/LO are updated at the edge that clears busy.
  - MTHI/MTLO: the new value is visible in cycle T+1; `busy` stays 0.
- A new op may be accepted in the first cycle `busy`=0 (back-to-back, no dead cycle).
- `busy` is a registered output with no combinational path from `start`. The stall unit combines `start` with `busy` itself.

## Structure
- Shared package `mdu_pkg`: `MDU_*` op encodings (4-bit), FSM state enum, helpers `is_mul_op`, `is_div_op`, `is_signed_op`, `is_acc_op`.
- Sub-module `mdu_divider`: WIDTH-iteration restoring divider with start/done handshake, sign fixup and div-by-zero flag. The top holds the FSM, multiply latency counter, accumulate logic and HI/LO.

## Test plan
Defaults assumed: WIDTH=32, MUL_CYCLES=5.
1. MULT, d1=0xFFFFFFFF, d2=2 → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
2. DIV, d1=−7, d2=2 → `busy` high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, 7/2 → LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
3. MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0. MSUB 1×2 → HI=0, LO=0xFFFFFFFE.
4. Masking:
   - `start` with `req`=1 (MULT or MTHI, d1=0x1234) → `busy` stays 0, HI/LO unchanged.
   - `start` while busy → ignored; the first result is unaffected.
   - `req` pulse mid-multiply → completes normally.
5. DIV by zero from HI=0xAA, LO=0xBB → `busy` 33 cycles, HI/LO stay 0xAA/0xBB. Reset low 10 cycles into a DIV → `busy`, HI, LO = 0 immediately, without waiting for a clock.
6. Back-to-back: MULT accepted in the first cycle after `busy` falls → second result correct, and total busy cycles = 10.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and op-class decode helpers.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MADD  = 4'd5;
  localparam logic [3:0] MDU_MADDU = 4'd6;
  localparam logic [3:0] MDU_MSUB  = 4'd7;
  localparam logic [3:0] MDU_MSUBU = 4'd8;
  localparam logic [3:0] MDU_MTHI  = 4'd9;
  localparam logic [3:0] MDU_MTLO  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
  endfunction

  function automatic logic is_acc_op(input logic [3:0] op);
    return op inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  // start is the valid; the unit is ready when !busy && !req. An op transfers
  // only on an edge where start, ready and op != NONE all hold; otherwise it is dropped.
  logic             req;
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output req, start, op, d1, d2, input busy, hi, lo);
  modport slave  (input req, start, op, d1, d2, output busy, hi, lo);
endinterface

// File: rtl/mdu_divider.sv
// Iterative restoring divider: WIDTH shift/subtract cycles on magnitudes,
// then one cycle with done=1 where the signed results are presented.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             active;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? ('0 - v) : v;
  endfunction

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      cnt      <= '0;
      quo      <= mag(dividend, is_signed);
      rem      <= '0;
      dvs      <= mag(divisor, is_signed);
      q_neg    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg    <= is_signed && dividend[WIDTH-1];
      div_zero <= (divisor == '0);
    end else if (active) begin
      if (cnt == CW'(WIDTH)) begin
        active <= 1'b0;
      end else begin
        // Restore by keeping the shifted value when the trial subtract underflows.
        rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign done      = active && (cnt == CW'(WIDTH));
  assign quotient  = q_neg ? ('0 - quo) : quo;
  assign remainder = r_neg ? ('0 - rem) : rem;

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit with private HI/LO: fixed-latency multiply/accumulate,
// iterative divide, and single-edge mthi/mtlo.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  mdu_if.slave       bus,
  output mdu_state_e state_dbg
);
  localparam int CW = $clog2(MUL_CYCLES + 1);

  mdu_state_e         state, state_next;
  logic [CW-1:0]      mul_cnt;
  logic [3:0]         op_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               accept, mul_wr, div_wr;
  logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_result;
  logic               div_done, div_zero;
  logic [WIDTH-1:0]   div_q, div_r;

  assign accept = bus.start && !bus.req && (state == ST_IDLE) && (bus.op != MDU_NONE);

  assign ext_a   = is_signed_op(bus.op) ? {{WIDTH{bus.d1[WIDTH-1]}}, bus.d1} : {{WIDTH{1'b0}}, bus.d1};
  assign ext_b   = is_signed_op(bus.op) ? {{WIDTH{bus.d2[WIDTH-1]}}, bus.d2} : {{WIDTH{1'b0}}, bus.d2};
  assign product = ext_a * ext_b;

  always_comb begin
    mul_result = prod_q;
    if (is_acc_op(op_q)) begin
      mul_result = (op_q inside {MDU_MSUB, MDU_MSUBU}) ? (acc_q - prod_q) : (acc_q + prod_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mul_wr     = 1'b0;
    div_wr     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul_op(bus.op))      state_next = ST_MUL;
        else if (accept && is_div_op(bus.op)) state_next = ST_DIV;
      end
      ST_MUL: begin
        if (mul_cnt == CW'(MUL_CYCLES)) begin
          mul_wr     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          div_wr     = !div_zero;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_cnt <= '0;
      op_q    <= MDU_NONE;
      prod_q  <= '0;
      acc_q   <= '0;
    end else if (accept && is_mul_op(bus.op)) begin
      mul_cnt <= CW'(1);
      op_q    <= bus.op;
      prod_q  <= product;
      acc_q   <= {hi_q, lo_q};
    end else if (state == ST_MUL) begin
      mul_cnt <= mul_wr ? '0 : mul_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (accept && bus.op == MDU_MTHI) begin
      hi_q <= bus.d1;
    end else if (accept && bus.op == MDU_MTLO) begin
      lo_q <= bus.d1;
    end else if (mul_wr) begin
      {hi_q, lo_q} <= mul_result;
    end else if (div_wr) begin
      hi_q <= div_r;
      lo_q <= div_q;
    end
  end

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (reset),
    .start     (accept && is_div_op(bus.op)),
    .is_signed (is_signed_op(bus.op)),
    .dividend  (bus.d1),
    .divisor   (bus.d2),
    .done      (div_done),
    .div_zero  (div_zero),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign bus.busy  = (state != ST_IDLE);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases, masking, reset, back-to-back
// and a randomized sweep scored against a behavioural {HI,LO} model.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;

  logic       clk;
  logic       rst_n;
  mdu_state_e state_dbg;

  mdu_if #(.WIDTH(W)) bus ();

  mdu_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [2*W-1:0]   exp_q[$];
  logic [2*W-1:0]   mdl;
  logic [2*W-1:0]   got, exp_v;
  int               cyc;

  // behavioural reference for {HI,LO}
  function automatic logic [2*W-1:0] model_op(input logic [3:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [2*W-1:0] cur);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = (o inside {MDU_MULT, MDU_MADD, MDU_MSUB}) ? 64'(sa * sb) : ua * ub;
    case (o)
      MDU_MULT, MDU_MULTU: return p;
      MDU_MADD, MDU_MADDU: return cur + p;
      MDU_MSUB, MDU_MSUBU: return cur - p;
      MDU_DIV: begin
        if (b == '0) return cur;
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      MDU_DIVU: begin
        if (b == '0) return cur;
        return {32'(ua % ub), 32'(ua / ub)};
      end
      MDU_MTHI: return {a, cur[W-1:0]};
      MDU_MTLO: return {cur[2*W-1:W], a};
      default:  return cur;
    endcase
  endfunction

  // driver: issue one op, return number of cycles busy was observed high
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.d1 = a; bus.d2 = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NONE;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 1'b0; bus.start = 1'b0; bus.op = MDU_NONE; bus.d1 = '0; bus.d2 = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    n_checks++; if (bus.hi !== '0) begin n_fail++; $display("FAIL reset_hi: got %h exp 0", bus.hi); end
    n_checks++; if (bus.lo !== '0) begin n_fail++; $display("FAIL reset_lo: got %h exp 0", bus.lo); end
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state_dbg); end
    rst_n = 1'b1;
    mdl = '0;
  endtask

  task automatic test_mult();
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFE);
    run_op(MDU_MULT, 32'hFFFFFFFF, 32'd2, cyc);
    n_checks++; if (cyc != MC) begin n_fail++; $display("FAIL mult_busy: got %0d exp %0d", cyc, MC); end
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL mult_result: got %h exp %h", got, exp_v); end
    exp_q.push_back(64'h00000001_FFFFFFFE);
    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, cyc);
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL multu_result: got %h exp %h", got, exp_v); end
    mdl = exp_v;
  endtask

  task automatic test_div();
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    n_checks++; if (cyc != W + 1) begin n_fail++; $display("FAIL div_busy: got %0d exp %0d", cyc, W + 1); end
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL div_signed: got %h exp %h", got, exp_v); end
    exp_q.push_back(64'h00000001_00000003);
    run_op(MDU_DIVU, 32'd7, 32'd2, cyc);
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL divu: got %h exp %h", got, exp_v); end
    exp_q.push_back(64'h00000000_80000000);
    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL div_overflow: got %h exp %h", got, exp_v); end
    mdl = exp_v;
  endtask

  task automatic test_acc();
    run_op(MDU_MTHI, 32'h0, 32'h0, cyc);
    n_checks++; if (cyc != 0) begin n_fail++; $display("FAIL mthi_busy: got %0d exp 0", cyc); end
    n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL mthi_value: got %h exp 0", bus.hi); end
    run_op(MDU_MTLO, 32'hFFFFFFFF, 32'h0, cyc);
    n_checks++; if (bus.lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mtlo_value: got %h exp ffffffff", bus.lo); end
    exp_q.push_back(64'h00000001_00000000);
    run_op(MDU_MADDU, 32'd1, 32'd1, cyc);
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL maddu_result: got %h exp %h", got, exp_v); end
    exp_q.push_back(64'h00000000_FFFFFFFE);
    run_op(MDU_MSUB, 32'd1, 32'd2, cyc);
    n_checks++; if (cyc != MC) begin n_fail++; $display("FAIL msub_busy: got %0d exp %0d", cyc, MC); end
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL msub_result: got %h exp %h", got, exp_v); end
    mdl = exp_v;
  endtask

  task automatic test_mask();
    // req masks a multiply and an mthi
    @(negedge clk);
    bus.req = 1'b1; bus.start = 1'b1; bus.op = MDU_MULT; bus.d1 = 32'h1234; bus.d2 = 32'd3;
    @(negedge clk);
    bus.op = MDU_MTHI;
    @(negedge clk);
    bus.req = 1'b0; bus.start = 1'b0; bus.op = MDU_NONE;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL req_mask_busy: got %b exp 0", bus.busy); end
    got = {bus.hi, bus.lo};
    n_checks++; if (got !== mdl) begin n_fail++; $display("FAIL req_mask_hilo: got %h exp %h", got, mdl); end
    // start while busy is dropped
    exp_q.push_back(64'h00000000_0000000F);
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.d1 = 32'd3; bus.d2 = 32'd5;
    @(negedge clk);
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      bus.start = (cyc == 2); bus.op = MDU_MTHI; bus.d1 = 32'h5555;
      @(negedge clk);
    end
    bus.start = 1'b0; bus.op = MDU_NONE;
    n_checks++; if (cyc != MC) begin n_fail++; $display("FAIL busy_start_len: got %0d exp %0d", cyc, MC); end
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL busy_start_result: got %h exp %h", got, exp_v); end
    // req pulse mid-multiply does not abort
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF9);
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULT; bus.d1 = 32'hFFFFFFFF; bus.d2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NONE;
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      bus.req = (cyc == 2);
      @(negedge clk);
    end
    bus.req = 1'b0;
    n_checks++; if (cyc != MC) begin n_fail++; $display("FAIL req_mid_len: got %0d exp %0d", cyc, MC); end
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL req_mid_result: got %h exp %h", got, exp_v); end
    mdl = exp_v;
  endtask

  task automatic test_divzero_reset();
    run_op(MDU_MTHI, 32'hAA, 32'h0, cyc);
    run_op(MDU_MTLO, 32'hBB, 32'h0, cyc);
    exp_q.push_back(64'h000000AA_000000BB);
    run_op(MDU_DIV, 32'h55, 32'h0, cyc);
    n_checks++; if (cyc != W + 1) begin n_fail++; $display("FAIL divzero_busy: got %0d exp %0d", cyc, W + 1); end
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL divzero_hilo: got %h exp %h", got, exp_v); end
    // asynchronous reset mid-divide, checked between clock edges
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.d1 = 32'd1000; bus.d2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NONE;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b exp 0", bus.busy); end
    got = {bus.hi, bus.lo};
    n_checks++; if (got !== '0) begin n_fail++; $display("FAIL async_rst_hilo: got %h exp 0", got); end
    @(negedge clk);
    rst_n = 1'b1;
    mdl = '0;
  endtask

  task automatic test_back_to_back();
    int total;
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFE);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF4);
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULT; bus.d1 = 32'hFFFFFFFF; bus.d2 = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    total = 0;
    while (bus.busy && total < 100) begin total++; @(negedge clk); end
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL b2b_first: got %h exp %h", got, exp_v); end
    bus.start = 1'b1; bus.op = MDU_MULT; bus.d1 = 32'd3; bus.d2 = 32'hFFFFFFFC;
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NONE;
    while (bus.busy && total < 100) begin total++; @(negedge clk); end
    n_checks++; if (total != 2 * MC) begin n_fail++; $display("FAIL b2b_busy_total: got %0d exp %0d", total, 2 * MC); end
    got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL b2b_second: got %h exp %h", got, exp_v); end
    mdl = exp_v;
  endtask

  task automatic test_random();
    logic [3:0] ops[8];
    logic [3:0] o;
    logic [W-1:0] a, b;
    ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
    a = $urandom(); run_op(MDU_MTHI, a, '0, cyc); mdl = model_op(MDU_MTHI, a, '0, mdl);
    a = $urandom(); run_op(MDU_MTLO, a, '0, cyc); mdl = model_op(MDU_MTLO, a, '0, mdl);
    for (int i = 0; i < 24; i++) begin
      o = ops[$urandom_range(0, 7)];
      a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom();
      b = ($urandom_range(0, 6) == 0) ? 32'h0 : $urandom_range(0, 3) == 0 ? 32'(int'($urandom_range(0, 15)) - 8) : $urandom();
      mdl = model_op(o, a, b, mdl);
      exp_q.push_back(mdl);
      run_op(o, a, b, cyc);
      n_checks++;
      if (cyc != (is_div_op(o) ? W + 1 : MC)) begin
        n_fail++; $display("FAIL rand_busy op=%0d: got %0d cycles", o, cyc);
      end
      got = {bus.hi, bus.lo}; exp_v = exp_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h exp %h", o, a, b, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_acc();
    test_mask();
    test_divzero_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
